button_bank: RTL and testbench

BUTTON_BANK -- requirements
Module: button_bank

---
 rtl/btn_pkg.sv | 19 +
 rtl/btn_channel.sv | 119 +++++++++++
 rtl/button_bank.sv | 39 +++
 tb/tb_button_bank.sv | 109 ++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and default timing for the debounced button bank.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    localparam int DEF_N_BTN      = 4;
    localparam int DEF_DB_CYCLES  = 500000;
    localparam int DEF_RPT_DELAY  = 1500000;
    localparam int DEF_RPT_PERIOD = 375000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: synchroniser, debounce, edge pulses and auto-repeat FSM.
import btn_pkg::*;

module btn_channel #(
    parameter int DB_CYCLES  = DEF_DB_CYCLES,
    parameter int RPT_DELAY  = DEF_RPT_DELAY,
    parameter int RPT_PERIOD = DEF_RPT_PERIOD,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic vclk,
    input  logic rst,
    input  logic btn_raw,
    input  logic rpt_en,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic action
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam int RW = $clog2(max2(RPT_DELAY, RPT_PERIOD) + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(RPT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(RPT_PERIOD - 1);

    logic          s1, s2;
    logic          cand;
    logic [CW-1:0] cnt;
    logic          deb;
    logic          press_d, rel_d, rpt_d;
    logic [RW-1:0] rcnt, rcnt_n;
    rpt_state_t    state, nstate;

    // deb is the settled value; level trails it by one register
    // so press/release line up with the first cycle of the new level.
    always_ff @(posedge vclk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cand <= 1'b0;
            cnt  <= '0;
            deb  <= 1'b0;
        end else begin
            s1 <= ACTIVE_LOW ? ~btn_raw : btn_raw;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt == DB_LAST) begin
                deb <= cand;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press_d = deb & ~level;
    assign rel_d   = ~deb & level;

    always_comb begin
        nstate = state;
        rcnt_n = rcnt;
        rpt_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (press_d) begin
                    nstate = DELAY;
                    rcnt_n = '0;
                end
            end
            DELAY: begin
                if (!deb || !rpt_en) begin
                    nstate = IDLE;
                    rcnt_n = '0;
                end else if (rcnt == RD_LAST) begin
                    rpt_d  = 1'b1;
                    rcnt_n = '0;
                    nstate = REPEAT;
                end else begin
                    rcnt_n = rcnt + 1'b1;
                end
            end
            REPEAT: begin
                if (!deb || !rpt_en) begin
                    nstate = IDLE;
                    rcnt_n = '0;
                end else if (rcnt == RP_LAST) begin
                    rpt_d  = 1'b1;
                    rcnt_n = '0;
                end else begin
                    rcnt_n = rcnt + 1'b1;
                end
            end
            default: begin
                nstate = IDLE;
                rcnt_n = '0;
            end
        endcase
    end

    always_ff @(posedge vclk) begin
        if (rst) begin
            state         <= IDLE;
            rcnt          <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            action        <= 1'b0;
        end else begin
            state         <= nstate;
            rcnt          <= rcnt_n;
            level         <= deb;
            press         <= press_d;
            release_pulse <= rel_d;
            action        <= press_d | rpt_d;
        end
    end

endmodule

// File: rtl/button_bank.sv
// Bank of independent debounced buttons with press/release/auto-repeat strobes.
import btn_pkg::*;

module button_bank #(
    parameter int N_BTN      = DEF_N_BTN,
    parameter int DB_CYCLES  = DEF_DB_CYCLES,
    parameter int RPT_DELAY  = DEF_RPT_DELAY,
    parameter int RPT_PERIOD = DEF_RPT_PERIOD,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             vclk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] rpt_en,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] action
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DB_CYCLES (DB_CYCLES),
            .RPT_DELAY (RPT_DELAY),
            .RPT_PERIOD(RPT_PERIOD),
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_ch (
            .vclk         (vclk),
            .rst          (rst),
            .btn_raw      (btn_raw[i]),
            .rpt_en       (rpt_en[i]),
            .level        (level[i]),
            .press        (press[i]),
            .release_pulse(release_pulse[i]),
            .action       (action[i])
        );
    end

endmodule

// File: tb/tb_button_bank.sv
// Directed checks of button_bank with short debounce/repeat timings.
module tb_button_bank;

    logic       vclk = 1'b0;
    logic       rst;
    logic [1:0] btn_raw;
    logic [1:0] rpt_en;
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] release_pulse;
    logic [1:0] action;

    int total = 0;
    int bad   = 0;

    button_bank #(
        .N_BTN     (2),
        .DB_CYCLES (4),
        .RPT_DELAY (10),
        .RPT_PERIOD(3),
        .ACTIVE_LOW(1'b0)
    ) dut (
        .vclk         (vclk),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .rpt_en       (rpt_en),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse),
        .action       (action)
    );

    always #5 vclk = ~vclk;

    task automatic chk(input string tag, input int cyc,
                       input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        btn_raw = 2'b00;
        rpt_en  = 2'b00;
        repeat (3) @(posedge vclk);
        #1;
        rst = 1'b0;
    endtask

    function automatic bit is_rpt(input int c);
        return (c == 7) || (c == 17) || (c == 20) || (c == 23) ||
               (c == 26) || (c == 29) || (c == 32) || (c == 35);
    endfunction

    function automatic logic b1_raw(input int c);
        if (c >= 8) return 1'b1;
        return ((c / 2) % 2) == 0;
    endfunction

    initial begin
        do_reset();
        chk("rst_out", -1,
            {level, press, release_pulse, action}, 8'h00);

        // ch0: held 0..29 with repeat; ch1: bounce then held, no repeat
        for (int c = 0; c <= 45; c++) begin
            rpt_en  = 2'b01;
            btn_raw = {b1_raw(c), (c < 30) ? 1'b1 : 1'b0};
            @(posedge vclk);
            #1;
            chk("act0", c, {7'd0, action[0]}, {7'd0, is_rpt(c)});
            chk("prs0", c, {7'd0, press[0]}, {7'd0, c == 7});
            chk("lvl0", c, {7'd0, level[0]},
                {7'd0, (c >= 7) && (c <= 36)});
            chk("rel0", c, {7'd0, release_pulse[0]}, {7'd0, c == 37});
            chk("lvl1", c, {7'd0, level[1]}, {7'd0, c >= 15});
            chk("prs1", c, {7'd0, press[1]}, {7'd0, c == 15});
            chk("act1", c, {7'd0, action[1]}, {7'd0, c == 15});
            chk("rel1", c, {7'd0, release_pulse[1]}, 8'd0);
        end

        do_reset();
        // ch0 held with repeat, reset pulsed at cycle 15 mid-repeat
        for (int c = 0; c <= 30; c++) begin
            rpt_en  = 2'b01;
            btn_raw = 2'b01;
            rst     = (c == 15);
            @(posedge vclk);
            #1;
            if (c >= 15 && c <= 22)
                chk("rst_mid", c,
                    {level, press, release_pulse, action}, 8'h00);
            chk("r_prs0", c, {7'd0, press[0]},
                {7'd0, (c == 7) || (c == 23)});
            chk("r_act0", c, {7'd0, action[0]},
                {7'd0, (c == 7) || (c == 23)});
            chk("r_lvl0", c, {7'd0, level[0]},
                {7'd0, ((c >= 7) && (c < 15)) || (c >= 23)});
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
